// File: rtl/serial_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package serial_det_pkg;

    localparam int unsigned     SD_N       = 4;
    localparam logic [SD_N-1:0] SD_PATTERN = 4'b1011;
    localparam int unsigned     SD_CNT_W   = 8;

    // Bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at MAX; clr takes priority over inc.
module sat_counter #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Slides an N-bit window over a serial stream and flags every (overlapping) PATTERN hit.
module serial_pattern_detector
    import serial_det_pkg::*;
#(
    parameter int unsigned  N       = SD_N,
    parameter logic [N-1:0] PATTERN = SD_PATTERN,
    parameter int unsigned  CNT_W   = SD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic [N-1:0]     window,
    output logic             window_full,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned       FILL_W    = clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    logic [N-1:0]      window_q;
    logic [N-1:0]      window_d;
    logic              match_q;
    logic              match_d;
    logic [FILL_W-1:0] fill;
    logic              fill_full_next;

    sat_counter #(
        .W   (FILL_W),
        .MAX (FILL_MAX)
    ) u_fill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (en),
        .q   (fill)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (match_d),
        .q   (match_count)
    );

    // Window is full after this edge if it already was, or this bit is the Nth.
    assign fill_full_next = (fill == FILL_MAX) || (fill == FILL_LAST);

    always_comb begin
        window_d = window_q;
        match_d  = 1'b0;
        if (en) begin
            window_d = {window_q[N-2:0], din};
            match_d  = fill_full_next && (window_d == PATTERN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window_q <= '0;
            match_q  <= 1'b0;
        end else begin
            window_q <= window_d;
            match_q  <= match_d;
        end
    end

    assign window      = window_q;
    assign window_full = (fill == FILL_MAX);
    assign match       = match_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: default, PATTERN=0001 and CNT_W=2 instances share stimulus.
module tb_serial_pattern_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    logic [3:0] win_a, win_p, win_c;
    logic       full_a, full_p, full_c;
    logic       m_a, m_p, m_c;
    logic [7:0] cnt_a, cnt_p;
    logic [1:0] cnt_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .window(win_a), .window_full(full_a), .match(m_a), .match_count(cnt_a));

    serial_pattern_detector #(.N(4), .PATTERN(4'b0001), .CNT_W(8)) dut_p (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .window(win_p), .window_full(full_p), .match(m_p), .match_count(cnt_p));

    serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .window(win_c), .window_full(full_c), .match(m_c), .match_count(cnt_c));

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic d, input logic c);
        @(negedge clk);
        rst = r; en = e; din = d; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        if ({win_a, full_a, m_a, cnt_a} !== 14'd0) begin
            $display("FAIL reset: window=%b full=%b match=%b count=%0d, want all 0", win_a, full_a, m_a, cnt_a);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_single_hit;
        logic [3:0] bits;
        logic [3:0] expm;
        bits = 4'b1011;
        expm = 4'b0001;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            if (m_a !== expm[i]) begin
                $display("FAIL single_hit bit%0d: match=%b want %b", 3 - i, m_a, expm[i]);
                n_err++;
            end
            n_vec++;
        end
        if (win_a !== 4'b1011 || full_a !== 1'b1 || cnt_a !== 8'd1) begin
            $display("FAIL single_hit state: window=%b full=%b count=%0d want 1011 1 1", win_a, full_a, cnt_a);
            n_err++;
        end
        n_vec++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (m_a !== 1'b0 || cnt_a !== 8'd1) begin
            $display("FAIL single_hit pulse_end: match=%b count=%0d want 0 1", m_a, cnt_a);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_overlap;
        logic [6:0] bits;
        logic [6:0] expm;
        bits = 7'b1011011;
        expm = 7'b0001001;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            if (m_a !== expm[i]) begin
                $display("FAIL overlap bit%0d: match=%b want %b", 6 - i, m_a, expm[i]);
                n_err++;
            end
            n_vec++;
        end
        if (cnt_a !== 8'd2) begin
            $display("FAIL overlap count: got %0d want 2", cnt_a);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_enable_hold;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (win_a !== 4'b0010 || m_a !== 1'b0 || full_a !== 1'b0) begin
                $display("FAIL hold cyc%0d: window=%b match=%b full=%b want 0010 0 0", i, win_a, m_a, full_a);
                n_err++;
            end
            n_vec++;
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        if (win_a !== 4'b0101 || m_a !== 1'b0) begin
            $display("FAIL hold resume1: window=%b match=%b want 0101 0", win_a, m_a);
            n_err++;
        end
        n_vec++;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        if (win_a !== 4'b1011 || m_a !== 1'b1 || full_a !== 1'b1) begin
            $display("FAIL hold resume2: window=%b match=%b full=%b want 1011 1 1", win_a, m_a, full_a);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_fill_guard;
        logic [3:0] bits;
        logic [3:0] expw [4];
        expw = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bits = 4'b0001;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        if (m_p !== 1'b0 || win_p !== 4'b0001 || full_p !== 1'b0) begin
            $display("FAIL fill_guard first: match=%b window=%b full=%b want 0 0001 0", m_p, win_p, full_p);
            n_err++;
        end
        n_vec++;
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            if (win_p !== expw[3 - i] || m_p !== (i == 0)) begin
                $display("FAIL fill_guard bit%0d: window=%b match=%b want %b %b", 3 - i, win_p, m_p, expw[3 - i], i == 0);
                n_err++;
            end
            n_vec++;
        end
        if (full_p !== 1'b1 || cnt_p !== 8'd1) begin
            $display("FAIL fill_guard end: full=%b count=%0d want 1 1", full_p, cnt_p);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_saturate_clear;
        logic [1:0] expc [5];
        expc = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int h = 0; h < 5; h++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (m_c !== 1'b1 || cnt_c !== expc[h]) begin
                $display("FAIL saturate hit%0d: match=%b count=%0d want 1 %0d", h + 1, m_c, cnt_c, expc[h]);
                n_err++;
            end
            n_vec++;
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        if (cnt_c !== 2'd0 || m_c !== 1'b1 || win_c !== 4'b1011) begin
            $display("FAIL clear_vs_hit: count=%0d match=%b window=%b want 0 1 1011", cnt_c, m_c, win_c);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_midstream_reset;
        logic [3:0] bits;
        bits = 4'b1011;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        if ({win_a, full_a, m_a, cnt_a} !== 14'd0) begin
            $display("FAIL mid_reset: window=%b full=%b match=%b count=%0d want all 0", win_a, full_a, m_a, cnt_a);
            n_err++;
        end
        n_vec++;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        if (m_a !== 1'b0 || win_a !== 4'b0001) begin
            $display("FAIL mid_reset stale: match=%b window=%b want 0 0001", m_a, win_a);
            n_err++;
        end
        n_vec++;
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, bits[i], 1'b0);
            if (m_a !== (i == 0)) begin
                $display("FAIL mid_reset refill bit%0d: match=%b want %b", 3 - i, m_a, i == 0);
                n_err++;
            end
            n_vec++;
        end
        if (cnt_a !== 8'd1) begin
            $display("FAIL mid_reset count: got %0d want 1", cnt_a);
            n_err++;
        end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_overlap();
        test_enable_hold();
        test_fill_guard();
        test_saturate_clear();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1);
    end

endmodule
